lsu_dmem: RTL and testbench
===========================

# lsu_dmem

Data-memory responder on the far end of the load/store unit's memory port. It accepts one read and/or one write request per cycle, returns read data after a fixed, parameterised latency with a matching valid strobe, and commits writes on the clock edge. Sits between the LSU and the top level, where it replaces the testbench behavioural memory. It also provides a preload port for program and data images, and sticky error flags for bad addresses.

## Interface
- DEPTH_WORDS, 1024: number of 64-bit words; byte address space is 0 .. DEPTH_WORDS*8-1.
- READ_LATENCY, 0: cycles from a request cycle to its `mem_rvalid` cycle; legal range 0..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_ren  in  1  read request, sampled every cycle.
- mem_raddr  in  64  read byte address.
- mem_rvalid  out  1  read response valid.
- mem_rdata  out  64  read response data.
- mem_wen  in  1  write request, sampled every cycle.
- mem_waddr  in  64  write byte address.
- mem_wdata  in  64  write data, full 64-bit word.
- ld_en  in  1  preload write enable.
- ld_addr  in  64  preload byte address.
- ld_data  in  64  preload data.
- err_misaligned  out  1  sticky: a request had addr[2:0] != 0.
- err_oob  out  1  sticky: a request had addr >= DEPTH_WORDS*8.

## Operation
- Word index = addr[3 +: $clog2(DEPTH_WORDS)]. In-range test uses the full 64-bit address.
- Each cycle with `mem_ren`=1 is one independent read request. A request held high for N cycles produces N responses, in order. No backpressure exists.
- Read path:
  - Read data is captured at request time, from the array with write-first forwarding.
  - If `mem_wen` is high in the same cycle and its word index equals the read word index, `mem_wdata` is returned, provided that write is legal.
  - Writes after request time never alter an in-flight response.
- READ_LATENCY=0: `mem_rvalid` = `mem_ren` combinationally; `mem_rdata` is the forwarded or array word combinationally.
- READ_LATENCY=L>=1: L-stage shift pipeline of {valid, data}. Stage 0 loads on the edge ending the request cycle. The last stage drives the outputs.
- `mem_rdata` is 64'd0 whenever `mem_rvalid`=0.
- Misaligned read: response is the aligned-down word and sets `err_misaligned`.
- Out-of-bounds read: response is still delivered (`mem_rvalid`=1) with data 0, and sets `err_oob`.
- Write: commits `mem_wdata` to the word on the edge ending a cycle with `mem_wen`=1. Misaligned or out-of-bounds writes are dropped and set the corresponding flag.
- Preload: same address rules as writes, but never sets error flags; illegal preloads are silently dropped.
  - If `ld_en` and `mem_wen` target the same word in the same cycle, `mem_wen` wins.
  - Preload data is not forwarded to reads.
- Error flags clear only on reset.

## Timing
- Reset values: `mem_rvalid`=0, `mem_rdata`=0, `err_misaligned`=0, `err_oob`=0, all pipeline valid bits 0.
- Array contents are not reset and persist across reset.
- While `rst`=1, all requests and preloads are ignored. No array writes occur and no flags set.
- Reset asserted mid-operation: in-flight reads are discarded immediately, and no `mem_rvalid` is produced for any request issued before reset deasserts.
- Latency: a request in cycle t yields `mem_rvalid`=1 in cycle t+READ_LATENCY. Throughput is one read plus one write per cycle, sustained.
- A write in cycle t is visible to a read requested in cycle t (forwarding) and in every later cycle.
- Flags rise on the edge ending the offending request cycle.

## Test plan
- Write/readback, READ_LATENCY=0:
  - `mem_wen`=1, waddr=0x40, wdata=0xDEADBEEF_0000_0001; next cycle `mem_ren`=1, raddr=0x40.
  - Expect `mem_rvalid`=1 with rdata=0xDEADBEEF_00000001 in that same cycle.
- Forwarding and pipelining, READ_LATENCY=2:
  - Preload 0x10 := 5. In cycle t, write 0x10 := 7 and read 0x10.
  - Expect rvalid in t+2 with data 7.
- Back-to-back streaming, READ_LATENCY=2:
  - Preload 0x0..0x38 with 0..7. Hold `mem_ren` for 8 cycles with addresses 0x0, 0x8, … 0x38.
  - Expect 8 consecutive valid cycles with data 0..7, then `mem_rvalid`=0 and `mem_rdata`=0.
- Error handling, DEPTH_WORDS=1024:
  - Read 0x2000: expect rvalid with data 0 and `err_oob`=1.
  - Write 0x13 := 9: dropped, `err_misaligned`=1. A subsequent read of 0x10 returns its prior value.
  - Flags stay high until reset.
- Async reset mid-flight, READ_LATENCY=3:
  - Issue reads in cycles t and t+1, then pulse `rst` between edges in cycle t+2.
  - Expect `mem_rvalid`=0 immediately and in all later cycles.
  - A read after reset returns preloaded data, proving the array survived reset.
- Port collision: `ld_en` (0x20 := 1) and `mem_wen` (0x20 := 2) in the same cycle; readback 0x20 returns 2.

Source files
------------

// File: rtl/lsu_dmem.sv
// lsu_dmem: data-memory responder for the LSU memory port.
//
// Purpose
//   Services one read and one write per cycle against a DEPTH_WORDS x 64-bit
//   array. Read data is captured at request time, with write-first forwarding.
//   It is then returned after READ_LATENCY cycles, together with a valid
//   strobe. A preload port fills program and data images. Sticky flags record
//   misaligned and out-of-bounds requests.
//
// Parameters
//   DEPTH_WORDS   number of 64-bit words. The byte address space is
//                 0 .. DEPTH_WORDS*8-1.
//   READ_LATENCY  number of cycles from a request to its mem_rvalid. The
//                 legal range is 0..4.
//
// Ports
//   clk, rst               clock and asynchronous active-high reset
//   mem_ren, mem_raddr     read request and byte address
//   mem_rvalid, mem_rdata  read response. Data is zero when not valid.
//   mem_wen, mem_waddr,    write request. Always a full 64-bit word.
//   mem_wdata
//   ld_en, ld_addr,        preload write. Sets no flags and is not forwarded.
//   ld_data
//   err_misaligned         sticky flag: a request had addr[2:0] != 0
//   err_oob                sticky flag: a request had addr >= DEPTH_WORDS*8
module lsu_dmem #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic [63:0] mem_raddr,
  output logic        mem_rvalid,
  output logic [63:0] mem_rdata,
  input  logic        mem_wen,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  input  logic        ld_en,
  input  logic [63:0] ld_addr,
  input  logic [63:0] ld_data,
  output logic        err_misaligned,
  output logic        err_oob
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'd8;

  logic [63:0] mem_array [DEPTH_WORDS];

  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] lidx;
  logic             r_aligned;
  logic             r_inrange;
  logic             w_aligned;
  logic             w_inrange;
  logic             l_aligned;
  logic             l_inrange;
  logic             w_commit;
  logic             l_commit;
  logic             req_valid;
  logic [63:0]      read_word;

  // The word index ignores the upper address bits. The range checks use the
  // full 64-bit address, so an aliased high address can never reach the array.
  assign ridx = mem_raddr[3 +: IDX_W];
  assign widx = mem_waddr[3 +: IDX_W];
  assign lidx = ld_addr[3 +: IDX_W];

  assign r_aligned = (mem_raddr[2:0] == 3'b000);
  assign w_aligned = (mem_waddr[2:0] == 3'b000);
  assign l_aligned = (ld_addr[2:0] == 3'b000);
  assign r_inrange = (mem_raddr < LIMIT);
  assign w_inrange = (mem_waddr < LIMIT);
  assign l_inrange = (ld_addr < LIMIT);

  // Nothing reaches the array while reset is held.
  assign w_commit = ~rst & mem_wen & w_aligned & w_inrange;
  // The LSU write has priority over a preload of the same word.
  assign l_commit = ~rst & ld_en & l_aligned & l_inrange &
                    ~(w_commit && (lidx == widx));

  assign req_valid = mem_ren & ~rst;

  // Request-time data. A legal write to the same word in this cycle is
  // forwarded. An out-of-range read returns zero but is still answered.
  always_comb begin
    read_word = 64'd0;
    if (r_inrange) begin
      if (w_commit && (widx == ridx)) begin
        read_word = mem_wdata;
      end else begin
        read_word = mem_array[ridx];
      end
    end
  end

  // The array contents are deliberately left out of reset, so that preloaded
  // images survive a reset pulse.
  always_ff @(posedge clk) begin
    if (l_commit) begin
      mem_array[lidx] <= ld_data;
    end
    if (w_commit) begin
      mem_array[widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_misaligned <= 1'b0;
      err_oob        <= 1'b0;
    end else begin
      if ((mem_ren && !r_aligned) || (mem_wen && !w_aligned)) begin
        err_misaligned <= 1'b1;
      end
      if ((mem_ren && !r_inrange) || (mem_wen && !w_inrange)) begin
        err_oob <= 1'b1;
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb
      assign mem_rvalid = req_valid;
      assign mem_rdata  = req_valid ? read_word : 64'd0;
    end else begin : g_pipe
      // Shift pipeline of {valid, data}. The data is stored as zero when
      // invalid, so the output needs no final masking.
      logic        valid_pipe [READ_LATENCY];
      logic [63:0] data_pipe  [READ_LATENCY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < READ_LATENCY; i++) begin
            valid_pipe[i] <= 1'b0;
            data_pipe[i]  <= 64'd0;
          end
        end else begin
          valid_pipe[0] <= mem_ren;
          data_pipe[0]  <= mem_ren ? read_word : 64'd0;
          for (int i = 1; i < READ_LATENCY; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            data_pipe[i]  <= data_pipe[i-1];
          end
        end
      end

      assign mem_rvalid = valid_pipe[READ_LATENCY-1];
      assign mem_rdata  = data_pipe[READ_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_lsu_dmem.sv
// Testbench for lsu_dmem. Three instances share one stimulus stream, with
// READ_LATENCY set to 0, 2 and 3. A reference model checks every cycle:
// a word array, a per-cycle response history and a reset boundary. A
// directed table and short hand-written sequences check fixed expected
// values.
module tb_lsu_dmem;

  localparam int          DEPTH = 1024;
  localparam logic [63:0] LIM   = 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren = 1'b0;
  logic [63:0] raddr = '0;
  logic        wen = 1'b0;
  logic [63:0] waddr = '0;
  logic [63:0] wdata = '0;
  logic        ld = 1'b0;
  logic [63:0] laddr = '0;
  logic [63:0] ldata = '0;

  logic        rv0, rv2, rv3, em0, em2, em3, eo0, eo2, eo3;
  logic [63:0] rd0, rd2, rd3;

  always #5 clk = ~clk;

  lsu_dmem #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_raddr(raddr),
    .mem_rvalid(rv0), .mem_rdata(rd0), .mem_wen(wen), .mem_waddr(waddr),
    .mem_wdata(wdata), .ld_en(ld), .ld_addr(laddr), .ld_data(ldata),
    .err_misaligned(em0), .err_oob(eo0));
  lsu_dmem #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_raddr(raddr),
    .mem_rvalid(rv2), .mem_rdata(rd2), .mem_wen(wen), .mem_waddr(waddr),
    .mem_wdata(wdata), .ld_en(ld), .ld_addr(laddr), .ld_data(ldata),
    .err_misaligned(em2), .err_oob(eo2));
  lsu_dmem #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_raddr(raddr),
    .mem_rvalid(rv3), .mem_rdata(rd3), .mem_wen(wen), .mem_waddr(waddr),
    .mem_wdata(wdata), .ld_en(ld), .ld_addr(laddr), .ld_data(ldata),
    .err_misaligned(em3), .err_oob(eo3));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_from = 0;

  // Reference model state
  logic [63:0] mm [DEPTH];
  bit          hv [int];
  logic [63:0] hd [int];
  bit          fm = 1'b0;
  bit          fo = 1'b0;

  // Samples taken in the most recent cycle
  logic        s_v0, s_v2, s_v3, s_m, s_o;
  logic [63:0] s_d0, s_d2, s_d3;

  typedef struct {
    logic        ren;
    logic [63:0] raddr;
    logic        wen;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic        ld;
    logic [63:0] laddr;
    logic [63:0] ldata;
    logic        ev;
    logic [63:0] ed;
    logic        em;
    logic        eo;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit legal(input logic [63:0] a);
    return (a[2:0] == 3'b000) && (a < LIM);
  endfunction

  // What a read of address a returns, given this cycle's write.
  function automatic logic [63:0] model_read(input logic [63:0] a);
    if (a >= LIM) return 64'd0;
    if (wen && legal(waddr) && (waddr >> 3) == (a >> 3)) return wdata;
    return mm[int'(a >> 3)];
  endfunction

  // The response due now from an instance of latency lat.
  function automatic logic [64:0] expect_resp(input int lat);
    int src = cyc - lat;
    if (src < valid_from || !hv.exists(src)) return 65'd0;
    return {hv[src], hd[src]};
  endfunction

  // One clock cycle. It is entered 1 time unit after a rising edge, with the
  // inputs already driven.
  task automatic tick();
    logic [64:0] e;
    @(negedge clk);
    hv[cyc] = ren;
    hd[cyc] = ren ? model_read(raddr) : 64'd0;
    e = expect_resp(0);
    chk("rvalid_L0", {63'd0, rv0}, {63'd0, e[64]});
    chk("rdata_L0", rd0, e[63:0]);
    e = expect_resp(2);
    chk("rvalid_L2", {63'd0, rv2}, {63'd0, e[64]});
    chk("rdata_L2", rd2, e[63:0]);
    e = expect_resp(3);
    chk("rvalid_L3", {63'd0, rv3}, {63'd0, e[64]});
    chk("rdata_L3", rd3, e[63:0]);
    chk("flags_L0", {62'd0, em0, eo0}, {62'd0, fm, fo});
    chk("flags_L2", {62'd0, em2, eo2}, {62'd0, fm, fo});
    chk("flags_L3", {62'd0, em3, eo3}, {62'd0, fm, fo});
    s_v0 = rv0; s_d0 = rd0; s_v2 = rv2; s_d2 = rd2; s_v3 = rv3; s_d3 = rd3;
    s_m = em0; s_o = eo0;
    @(posedge clk);
    if ((ren && raddr[2:0] != 3'b000) || (wen && waddr[2:0] != 3'b000)) fm = 1'b1;
    if ((ren && raddr >= LIM) || (wen && waddr >= LIM)) fo = 1'b1;
    if (ld && legal(laddr)) mm[int'(laddr >> 3)] = ldata;
    if (wen && legal(waddr)) mm[int'(waddr >> 3)] = wdata;
    cyc++;
    #1;
  endtask

  task automatic idle();
    ren = 1'b0; wen = 1'b0; ld = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; laddr = '0; ldata = '0;
  endtask

  // Reset pulse placed between two clock edges, with the inputs idle.
  task automatic async_reset();
    valid_from = cyc;
    rst = 1'b1;
    #2;
    chk("rst_rvalid_L0", {63'd0, rv0}, 64'd0);
    chk("rst_rvalid_L2", {63'd0, rv2}, 64'd0);
    chk("rst_rvalid_L3", {63'd0, rv3}, 64'd0);
    chk("rst_flags", {61'd0, em0, eo2, em3}, 64'd0);
    rst = 1'b0;
    fm = 1'b0;
    fo = 1'b0;
    tick();
  endtask

  function automatic vec_t mk(input logic r, input logic [63:0] ra,
                              input logic w, input logic [63:0] wa, input logic [63:0] wd,
                              input logic l, input logic [63:0] la, input logic [63:0] lv,
                              input logic ev, input logic [63:0] ed,
                              input logic em, input logic eo);
    vec_t v;
    v.ren = r; v.raddr = ra; v.wen = w; v.waddr = wa; v.wdata = wd;
    v.ld = l; v.laddr = la; v.ldata = lv;
    v.ev = ev; v.ed = ed; v.em = em; v.eo = eo;
    return v;
  endfunction

  function automatic logic [63:0] rand_addr();
    int r = int'($urandom_range(0, 19));
    if (r == 0) return 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(1, 7));
    if (r == 1) return LIM + 64'($urandom_range(0, 100)) * 8;
    if (r == 2) return 64'hFFFF_0000_0000_0000 | (64'($urandom_range(0, 15)) * 8);
    return 64'($urandom_range(0, 15)) * 8;
  endfunction

  initial begin
    // Reset state. Requests made while reset is held must be ignored.
    ren = 1'b1; raddr = 64'h13; wen = 1'b1; waddr = 64'h2000; wdata = 64'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid_L0", {63'd0, rv0}, 64'd0);
    chk("reset_rdata_L0", rd0, 64'd0);
    chk("reset_rvalid_L2", {63'd0, rv2}, 64'd0);
    chk("reset_rvalid_L3", {63'd0, rv3}, 64'd0);
    chk("reset_flags", {60'd0, em0, eo0, em3, eo3}, 64'd0);
    idle();
    rst = 1'b0;

    // Preload every word with a known pattern through the preload port.
    for (int i = 0; i < DEPTH; i++) begin
      ld = 1'b1; laddr = 64'(i) * 8; ldata = {32'(i), 32'(i) ^ 32'h5A5A_1234};
      tick();
    end
    idle();

    // Directed table. Expected values are for the latency-0 instance.
    tbl.push_back(mk(0, 0,     1, 64'h40, 64'hDEADBEEF_00000001, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h40, 0, 0, 0,                         0, 0, 0,   1, 64'hDEADBEEF_00000001, 0, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0,                  1, 64'h10, 5,     0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h10, 1, 64'h10, 7,            0, 0, 0,          1, 7, 0, 0));
    tbl.push_back(mk(0, 0,     1, 64'h20, 2,             1, 64'h20, 1,     0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h20, 0, 0, 0,                 0, 0, 0,          1, 2, 0, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0,                  1, 64'h28, 11,    0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h28, 0, 0, 0,                 1, 64'h28, 3,     1, 11, 0, 0));
    tbl.push_back(mk(1, 64'h28, 0, 0, 0,                 0, 0, 0,          1, 3, 0, 0));
    tbl.push_back(mk(0, 0,     1, 64'h33, 4,             1, 64'h30, 64'h99, 0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h30, 0, 0, 0,                 0, 0, 0,          1, 64'h99, 1, 0));
    tbl.push_back(mk(1, 64'h13, 0, 0, 0,                 1, 64'h2000, 1,   1, 7, 1, 0));
    tbl.push_back(mk(1, 64'h2000, 0, 0, 0,               0, 0, 0,          1, 0, 1, 0));
    tbl.push_back(mk(0, 0,     1, 64'h13, 9,             0, 0, 0,          0, 0, 1, 1));
    tbl.push_back(mk(1, 64'h10, 0, 0, 0,                 0, 0, 0,          1, 7, 1, 1));
    tbl.push_back(mk(0, 0,     0, 0, 0,                  0, 0, 0,          0, 0, 1, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      ren = tbl[i].ren; raddr = tbl[i].raddr;
      wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      ld = tbl[i].ld; laddr = tbl[i].laddr; ldata = tbl[i].ldata;
      tick();
      chk($sformatf("tbl%0d_rvalid", i), {63'd0, s_v0}, {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_rdata", i), s_d0, tbl[i].ed);
      chk($sformatf("tbl%0d_flags", i), {62'd0, s_m, s_o}, {62'd0, tbl[i].em, tbl[i].eo});
    end
    idle();

    // Forwarding through the latency-2 pipeline.
    ld = 1'b1; laddr = 64'h10; ldata = 64'd5;
    tick();
    idle();
    wen = 1'b1; waddr = 64'h10; wdata = 64'd7; ren = 1'b1; raddr = 64'h10;
    tick();
    idle();
    tick();
    tick();
    chk("fwd_L2_rvalid", {63'd0, s_v2}, 64'd1);
    chk("fwd_L2_rdata", s_d2, 64'd7);

    // Back-to-back streaming on the latency-2 instance.
    for (int i = 0; i < 8; i++) begin
      ld = 1'b1; laddr = 64'(i) * 8; ldata = 64'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 11; i++) begin
      ren = (i < 8); raddr = (i < 8) ? 64'(i) * 8 : 64'd0;
      tick();
      chk($sformatf("stream%0d_rvalid", i), {63'd0, s_v2},
          (i >= 2 && i < 10) ? 64'd1 : 64'd0);
      chk($sformatf("stream%0d_rdata", i), s_d2,
          (i >= 2 && i < 10) ? 64'(i - 2) : 64'd0);
    end
    idle();

    // Asynchronous reset while latency-3 reads are in flight.
    ld = 1'b1; laddr = 64'h30; ldata = 64'h55;
    tick();
    idle();
    ren = 1'b1; raddr = 64'h30;
    tick();
    tick();
    idle();
    async_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postrst%0d_rvalid_L3", i), {63'd0, s_v3}, 64'd0);
    end
    ren = 1'b1; raddr = 64'h30;
    tick();
    idle();
    tick();
    tick();
    tick();
    chk("postrst_read_rvalid_L3", {63'd0, s_v3}, 64'd1);
    chk("postrst_read_rdata_L3", s_d3, 64'h55);

    // Random traffic, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      ren = $urandom_range(0, 1) == 1; raddr = rand_addr();
      wen = $urandom_range(0, 2) == 0; waddr = rand_addr();
      wdata = {$urandom, $urandom};
      ld = $urandom_range(0, 3) == 0;
      laddr = ($urandom_range(0, 1) == 1) ? waddr : rand_addr();
      ldata = {$urandom, $urandom};
      tick();
    end
    idle();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
